inst_fetch: RTL and testbench

//   Instruction-fetch unit: the requesting side of the instruction ROM interface (8-bit addr in,
//   16-bit instruction out, combinational). Holds the PC, drives the ROM address, and captures

---
 rtl/inst_fetch_pkg.sv | 13 +
 rtl/inst_fetch_if.sv | 21 ++
 rtl/inst_fetch_fifo.sv | 40 ++++
 rtl/inst_fetch.sv | 45 ++++
 tb/tb_inst_fetch.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, defaults and the fetch FIFO entry type
package inst_fetch_pkg;
    localparam int ADDR_W = 8;
    localparam int INSTR_W = 16;
    localparam int FIFO_DEPTH = 2;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INSTR_W-1:0] instr_t;
    localparam addr_t RESET_PC_DEF = '0;
    typedef struct packed {
        addr_t pc;
        instr_t instr;
    } entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: ROM, redirect and decode handshake signals of the fetch unit
interface inst_fetch_if;
    import inst_fetch_pkg::*;
    logic fetch_en;
    addr_t rom_addr;
    instr_t rom_instr;
    logic redir_valid;
    addr_t redir_pc;
    logic if_valid;
    logic if_ready;
    instr_t if_instr;
    addr_t if_pc;
    modport master (
        input fetch_en, rom_instr, redir_valid, redir_pc, if_ready,
        output rom_addr, if_valid, if_instr, if_pc
    );
    modport slave (
        output fetch_en, rom_instr, redir_valid, redir_pc, if_ready,
        input rom_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/inst_fetch_fifo.sv
// inst_fetch_fifo: synchronous prefetch FIFO with flush, count and zeroed head when empty
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_flush,
    input  entry_t i_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output entry_t o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    entry_t r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    // pointer and occupancy tracking; flush empties the FIFO in one cycle
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (i_pop) r_rd <= r_rd + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    // storage needs no reset: entries are only visible through a nonzero count
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
    assign o_count = r_count;
    assign o_head = (r_count != '0) ? r_mem[r_rd] : '0;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC sequencing, ROM addressing and redirect control feeding the prefetch FIFO
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter addr_t RESET_PC = RESET_PC_DEF
) (
    input logic clk,
    input logic rst,
    inst_fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH+1);
    logic [CW-1:0] w_count;
    entry_t w_head;
    entry_t w_entry;
    addr_t r_pc;
    logic w_valid;
    logic w_pop;
    logic w_push;
    assign w_valid = w_count != '0;
    assign w_pop = w_valid & bus.if_ready;
    // a full FIFO may still accept a word when the head leaves in the same cycle
    assign w_push = bus.fetch_en & ~bus.redir_valid & ((w_count < CW'(DEPTH)) | w_pop);
    assign w_entry = '{pc: r_pc, instr: bus.rom_instr};
    // PC: redirect reloads, each push advances with natural wrap
    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else if (bus.redir_valid) r_pc <= bus.redir_pc;
        else if (w_push) r_pc <= r_pc + addr_t'(1);
    end
    inst_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .i_push(w_push),
        .i_pop(w_pop),
        .i_flush(bus.redir_valid),
        .i_data(w_entry),
        .o_count(w_count),
        .o_head(w_head)
    );
    assign bus.rom_addr = r_pc;
    assign bus.if_valid = w_valid;
    assign bus.if_instr = w_head.instr;
    assign bus.if_pc = w_head.pc;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus random traffic against a queue-based fetch model
module tb_inst_fetch;
    import inst_fetch_pkg::*;
    logic clk = 0;
    logic rst;
    int n_pass = 0;
    int n_tot = 0;
    bit started = 0;
    addr_t mpc;
    addr_t qpc[$];
    instr_t qin[$];

    inst_fetch_if bus();
    inst_fetch #(.DEPTH(2), .RESET_PC(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    assign bus.rom_instr = 16'hA000 | {8'h00, bus.rom_addr};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        else n_pass++;
    endtask

    // reference: a queue of fetched words and a PC, advanced once per clock
    always @(posedge clk) begin
        bit p, u;
        if (rst) begin
            qpc.delete();
            qin.delete();
            mpc = 8'h00;
            started = 1;
        end else if (started) begin
            if (bus.redir_valid) begin
                qpc.delete();
                qin.delete();
                mpc = bus.redir_pc;
            end else begin
                p = (qpc.size() != 0) && bus.if_ready;
                u = bus.fetch_en && (qpc.size() < 2 || p);
                if (p) begin
                    void'(qpc.pop_front());
                    void'(qin.pop_front());
                end
                if (u) begin
                    qpc.push_back(mpc);
                    qin.push_back(16'hA000 + {8'h00, mpc});
                    mpc = mpc + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", {31'd0, bus.if_valid}, {31'd0, qpc.size() != 0});
            chk("m_rom_addr", {24'd0, bus.rom_addr}, {24'd0, mpc});
            chk("m_if_pc", {24'd0, bus.if_pc}, {24'd0, (qpc.size() != 0) ? qpc[0] : 8'h00});
            chk("m_if_instr", {16'd0, bus.if_instr}, {16'd0, (qin.size() != 0) ? qin[0] : 16'h0000});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        rst = 1;
        bus.fetch_en = 0;
        bus.if_ready = 0;
        bus.redir_valid = 0;
        bus.redir_pc = 0;
        step();
        step();
        look();
        chk("rst_valid", {31'd0, bus.if_valid}, 0);
        chk("rst_rom_addr", {24'd0, bus.rom_addr}, 0);
        chk("rst_if_pc", {24'd0, bus.if_pc}, 0);
        chk("rst_if_instr", {16'd0, bus.if_instr}, 0);
        rst = 0;
        bus.fetch_en = 1;
        bus.if_ready = 1;
        step();
        look();
        chk("first_valid", {31'd0, bus.if_valid}, 1);
        chk("first_pc", {24'd0, bus.if_pc}, 0);
        chk("first_instr", {16'd0, bus.if_instr}, 32'hA000);
        for (int i = 1; i <= 3; i++) begin
            step();
            look();
            chk("stream_pc", {24'd0, bus.if_pc}, i);
        end
        rst = 1;
        bus.if_ready = 0;
        step();
        rst = 0;
        repeat (5) step();
        look();
        chk("stall_valid", {31'd0, bus.if_valid}, 1);
        chk("stall_pc", {24'd0, bus.if_pc}, 0);
        chk("stall_rom_addr", {24'd0, bus.rom_addr}, 2);
        bus.if_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            look();
            chk("resume_pc", {24'd0, bus.if_pc}, i);
        end
        bus.if_ready = 0;
        step();
        step();
        bus.redir_valid = 1;
        bus.redir_pc = 8'h10;
        step();
        bus.redir_valid = 0;
        look();
        chk("redir_valid", {31'd0, bus.if_valid}, 0);
        chk("redir_rom_addr", {24'd0, bus.rom_addr}, 32'h10);
        step();
        look();
        chk("redir_pc", {24'd0, bus.if_pc}, 32'h10);
        chk("redir_instr", {16'd0, bus.if_instr}, 32'hA010);
        bus.redir_valid = 1;
        bus.redir_pc = 8'hFE;
        bus.if_ready = 1;
        step();
        bus.redir_valid = 0;
        look();
        chk("wrap_gap", {31'd0, bus.if_valid}, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            look();
            chk("wrap_pc", {24'd0, bus.if_pc}, (254 + i) % 256);
        end
        bus.if_ready = 0;
        step();
        step();
        bus.fetch_en = 0;
        bus.if_ready = 1;
        step();
        look();
        chk("drain_pc", {24'd0, bus.if_pc}, 2);
        step();
        look();
        chk("drain_empty", {31'd0, bus.if_valid}, 0);
        chk("frozen_addr", {24'd0, bus.rom_addr}, 3);
        step();
        look();
        chk("frozen_addr2", {24'd0, bus.rom_addr}, 3);
        bus.fetch_en = 1;
        step();
        look();
        chk("refetch_pc", {24'd0, bus.if_pc}, 3);
        bus.if_ready = 0;
        step();
        step();
        rst = 1;
        bus.redir_valid = 1;
        bus.redir_pc = 8'h33;
        step();
        rst = 0;
        bus.redir_valid = 0;
        look();
        chk("rst_over_redir_valid", {31'd0, bus.if_valid}, 0);
        chk("rst_over_redir_addr", {24'd0, bus.rom_addr}, 0);
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            bus.fetch_en = ($urandom_range(0, 9) < 8);
            bus.if_ready = ($urandom_range(0, 9) < 6);
            bus.redir_valid = ($urandom_range(0, 19) == 0);
            bus.redir_pc = addr_t'($urandom);
        end
        step();
        look();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
